// File: rtl/apb_timer_if.sv
// APB bus bundle between the AHB-to-APB bridge and the timer slave.
// The bridge has no PREADY/PSLVERR, so neither appears here.
interface apb_timer_if;
    logic        psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    modport master (
        output psel, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  psel, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA
    );
endinterface

// File: rtl/apb_timer.sv
// APB down-counter timer: prescaler, periodic/one-shot modes, sticky expiry
// flag (W1C) and a level interrupt. Zero wait states; PRDATA is captured at
// the setup-phase edge and held through the access phase.
// Optional feature macro: APB_TIMER_PRESCALER_EN (prescaler present when
// defined; otherwise every enabled cycle is a tick and CTRL[15:8] reads 0).
module apb_timer #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    apb_timer_if.slave apb,
    output logic       irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;

    logic [2:0]       addr;
    logic             wr_stb;
    logic             rd_cap;
    logic             wr_ctrl;
    logic             wr_load;
    logic             wr_status;

    logic             en_q, en_d;
    logic             oneshot_q, oneshot_d;
    logic             irqen_q, irqen_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exp_q, exp_d;
    logic [31:0]      prdata_q, prdata_d;
    logic [31:0]      rdata;

    logic             tick;
    logic             tick_ok;
    logic             expire;
    logic             unused_bits;

    assign addr      = apb.PADDR[4:2];
    assign wr_stb    = apb.psel & apb.PENABLE & apb.PWRITE;
    assign rd_cap    = apb.psel & ~apb.PENABLE & ~apb.PWRITE;
    assign wr_ctrl   = wr_stb && (addr == A_CTRL);
    assign wr_load   = wr_stb && (addr == A_LOAD);
    assign wr_status = wr_stb && (addr == A_STATUS);

`ifdef APB_TIMER_PRESCALER_EN
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;

    assign tick = en_q && (pre_q == prescale_q);

    // Prescale counter: idle at 0 while disabled, restarts on tick or LOAD write
    always_comb begin
        pre_d = pre_q + 1'b1;
        if (!en_q || wr_load || tick) begin
            pre_d = '0;
        end
        prescale_d = prescale_q;
        if (wr_ctrl) begin
            prescale_d = apb.PWDATA[8 +: PRE_W];
        end
    end

    // Prescaler state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_q      <= '0;
            prescale_q <= '0;
        end else begin
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
        end
    end
`else
    assign tick = en_q;
`endif

    // A LOAD write or a disabling CTRL write on the same edge suppresses the tick
    assign tick_ok = tick & ~wr_load & ~(wr_ctrl & ~apb.PWDATA[0]);
    assign expire  = tick_ok && (count_q == '0);

    // Control, reload and counter next-state; software writes override hardware
    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irqen_d   = irqen_q;
        load_d    = load_q;
        count_d   = count_q;

        if (tick_ok) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (oneshot_q) begin
                count_d = '0;
                en_d    = 1'b0;
            end else begin
                count_d = load_q;
            end
        end

        if (wr_ctrl) begin
            en_d      = apb.PWDATA[0];
            oneshot_d = apb.PWDATA[1];
            irqen_d   = apb.PWDATA[2];
        end

        if (wr_load) begin
            load_d  = apb.PWDATA[CNT_W-1:0];
            count_d = apb.PWDATA[CNT_W-1:0];
        end

        exp_d = expire | (exp_q & ~(wr_status & apb.PWDATA[0]));
    end

    // Read mux, captured only at the setup-phase edge
    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL: begin
                rdata[0] = en_q;
                rdata[1] = oneshot_q;
                rdata[2] = irqen_q;
`ifdef APB_TIMER_PRESCALER_EN
                rdata[8 +: PRE_W] = prescale_q;
`endif
            end
            A_LOAD:   rdata[CNT_W-1:0] = load_q;
            A_COUNT:  rdata[CNT_W-1:0] = count_q;
            A_STATUS: rdata[0] = exp_q;
            default:  rdata = '0;
        endcase
        prdata_d = rd_cap ? rdata : prdata_q;
    end

    // Timer and bus register state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irqen_q   <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
            exp_q     <= 1'b0;
            prdata_q  <= '0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irqen_q   <= irqen_d;
            load_q    <= load_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
            prdata_q  <= prdata_d;
        end
    end

    assign apb.PRDATA = prdata_q;
    assign irq        = exp_q & irqen_q;

    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA, 32'(PRE_W)};

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer. Read expectations are queued when the
// setup phase is driven and popped when PRDATA is valid in the access phase.
`timescale 1ns/1ps
module tb_apb_timer;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PRE_W = 8;
`ifdef APB_TIMER_PRESCALER_EN
    localparam bit HAS_PRE = 1'b1;
`else
    localparam bit HAS_PRE = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    int m_load;
    int m_pre;
    int m_en_edge;

    apb_timer_if bus();

    apb_timer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .apb   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // COUNT as it stands after edge c of a periodic run
    function automatic logic [31:0] model_count(input int c);
        int k, t;
        k = c - m_en_edge;
        if (k < 0) return 32'(m_load);
        t = k / (m_pre + 1);
        return 32'(m_load - (t % (m_load + 1)));
    endfunction

    function automatic logic [31:0] model_status(input int c);
        int k;
        k = c - m_en_edge;
        return (k >= (m_load + 1) * (m_pre + 1)) ? 32'd1 : 32'd0;
    endfunction

    task automatic bus_idle();
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    // Returns in the access phase; acc_edge is the edge that performs the write
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output int acc_edge);
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        acc_edge    = cyc + 2;
        @(negedge clk);
        bus.PENABLE = 1'b1;
    endtask

    // kind: 0 fixed value, 1 periodic COUNT model, 2 periodic STATUS model
    task automatic apb_read(input logic [31:0] addr, input string name, input int kind, input logic [31:0] fixed);
        logic [31:0] exp, got;
        string nm;
        @(negedge clk);
        case (kind)
            1:       exp = model_count(cyc);
            2:       exp = model_status(cyc);
            default: exp = fixed;
        endcase
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus.psel    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = addr;
        bus.PWDATA  = '0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        got = bus.PRDATA;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected value queued, PRDATA=%h", name, got);
        end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: PRDATA=%h expected %h", nm, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        bus.psel = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.PRDATA !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: PRDATA=%h irq=%b expected 0/0", bus.PRDATA, irq);
        end
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apb_read(32'(i * 4), $sformatf("reset_off%0d", i), 0, 32'd0);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_irq%0d: irq=%b expected 0", i, irq);
            end
        end
    endtask

    task automatic test_periodic();
        int e, d;
        apb_write(32'h4, 32'd3, d);
        apb_write(32'h0, 32'h1, e);
        m_load = 3; m_pre = 0; m_en_edge = e;
        for (int i = 0; i < 10; i++) begin
            apb_read(32'h8, $sformatf("periodic_count%0d", i), 1, '0);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL periodic_irq%0d: irq=%b expected 0", i, irq);
            end
            for (int j = 0; j < i % 3; j++) bus_idle();
        end
        apb_read(32'hC, "periodic_status", 2, '0);
        apb_write(32'h0, 32'h0, d);
        apb_write(32'hC, 32'h1, d);
        apb_read(32'hC, "periodic_w1c", 0, 32'd0);
    endtask

    task automatic test_oneshot();
        int e, d, lat, want;
        apb_write(32'h4, 32'd2, d);
        apb_write(32'h0, 32'h307, e);
        want = 3 * (HAS_PRE ? 4 : 1);
        lat = -1;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            bus_idle();
            if (irq === 1'b1) lat = cyc - e;
        end
        checks++;
        if (lat != want) begin
            errors++;
            $display("FAIL oneshot_latency: %0d cycles expected %0d", lat, want);
        end
        repeat (5) bus_idle();
        apb_read(32'h0, "oneshot_ctrl", 0, HAS_PRE ? 32'h306 : 32'h006);
        apb_read(32'h8, "oneshot_count", 0, 32'd0);
        apb_read(32'hC, "oneshot_status", 0, 32'd1);
        apb_write(32'hC, 32'h1, d);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_before_clear: irq=%b expected 1", irq);
        end
        bus_idle();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_after_clear: irq=%b expected 0", irq);
        end
        apb_read(32'hC, "oneshot_status_cleared", 0, 32'd0);
    endtask

    task automatic test_collision();
        int e, d, l;
        // LOAD=0 periodic expires on every edge, so any W1C collides with a set
        apb_write(32'h4, 32'd0, d);
        apb_write(32'h0, 32'h5, e);
        repeat (3) bus_idle();
        apb_write(32'hC, 32'h1, d);
        bus_idle();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL collide_w1c_irq: irq=%b expected 1", irq);
        end
        apb_read(32'hC, "collide_w1c_status", 0, 32'd1);
        apb_write(32'h0, 32'h0, d);
        apb_write(32'hC, 32'h1, d);
        apb_read(32'hC, "collide_status_after_stop", 0, 32'd0);
        // LOAD written while ticking every edge
        apb_write(32'h4, 32'd50, d);
        apb_write(32'h0, 32'h1, e);
        repeat (2) bus_idle();
        apb_write(32'h4, 32'd9, l);
        apb_read(32'h8, "collide_load_tick", 0, 32'd9);
        apb_write(32'h0, 32'h0, d);
        apb_read(32'h8, "collide_disable_tick", 0, 32'(9 - (d - 1 - l)));
        apb_read(32'hC, "collide_no_expiry", 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        int d;
        apb_write(32'h4, 32'hA5, d);
        apb_read(32'h4, "b2b_load", 0, 32'h0000_00A5);
        apb_read(32'h14, "b2b_off5", 0, 32'd0);
        apb_write(32'h10, 32'hFFFF_FFFF, d);
        apb_read(32'h4, "b2b_load_kept", 0, 32'h0000_00A5);
        apb_read(32'h0, "b2b_ctrl_kept", 0, 32'd0);
        bus_idle();
    endtask

    task automatic test_reset_mid();
        int e, d;
        apb_write(32'h4, 32'd7, d);
        apb_write(32'h0, 32'h5, e);
        repeat (12) bus_idle();
        apb_read(32'h4, "rstmid_load", 0, 32'd7);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_irq_before: irq=%b expected 1", irq);
        end
        bus_idle();
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || bus.PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_async: irq=%b PRDATA=%h expected 0/0", irq, bus.PRDATA);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (10) bus_idle();
        apb_read(32'h0, "rstmid_ctrl", 0, 32'd0);
        apb_read(32'h4, "rstmid_load_after", 0, 32'd0);
        apb_read(32'h8, "rstmid_count", 0, 32'd0);
        apb_read(32'hC, "rstmid_status", 0, 32'd0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_irq_after: irq=%b expected 0", irq);
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
# apb_timer

APB slave down-counter timer with prescaler, periodic/one-shot modes, sticky expiry flag and level interrupt. It sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's PADDR, PWDATA, PWRITE and PENABLE, plus one decoded select line derived from psel_en and HADDR[14:12]. It returns PRDATA with zero wait states, because the bridge has no PREADY or PSLVERR.

## Interface
- CNT_W, 32, counter and LOAD width (1..32); register bits above CNT_W read 0.
- PRE_W, 8, prescaler width (1..8); occupies CTRL[8+PRE_W-1:8].
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- psel  in  1  decoded APB select for this slave.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  only PADDR[4:2] decoded; other bits ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- irq  out  1  level interrupt, equal to STATUS.EXP & CTRL.IRQ_EN.

## Operation
- Register map (word offset PADDR[4:2]):
  - 0 CTRL (RW): bit0 EN; bit1 ONESHOT; bit2 IRQ_EN; [8+PRE_W-1:8] PRESCALE.
  - 1 LOAD (RW).
  - 2 COUNT (RO).
  - 3 STATUS: bit0 EXP, write-1-to-clear.
  - Offsets 4-7 read 0; writes to them are ignored.
- Write strobe is psel & PENABLE & PWRITE. Register update happens on that clock edge.
- Read capture:
  - PRDATA is loaded at the setup-phase edge, when psel & !PENABLE & !PWRITE. It therefore holds valid data throughout the access phase.
  - Otherwise PRDATA holds its value.
- Prescaler:
  - pre_cnt is cleared while EN=0.
  - While EN=1, pre_cnt increments each cycle. When pre_cnt==PRESCALE, a tick is generated and pre_cnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
- Counter, on each tick:
  - If COUNT!=0: COUNT decrements by 1.
  - If COUNT==0: expiry event. EXP is set to 1.
    - ONESHOT=0: COUNT reloads from LOAD.
    - ONESHOT=1: EN clears to 0 and COUNT stays 0.
- Period is (LOAD+1)*(PRESCALE+1) cycles.
- A write to LOAD also writes COUNT on the same edge, and clears pre_cnt.
- Simultaneous events:
  - A LOAD write on a tick edge takes priority. COUNT=new LOAD, and no decrement or expiry occurs that edge.
  - A hardware EXP set and a STATUS W1C on the same edge leave EXP=1 (set wins).
  - A CTRL write with EN=0 on a tick edge takes priority. No decrement or expiry occurs.
  - A CTRL write during a one-shot auto-clear of EN: the written EN value wins.
- LOAD=0 in periodic mode expires every tick.
- Reset mid-operation returns all state to reset values immediately, asynchronously.

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, STATUS=0, pre_cnt=0, PRDATA=0, irq=0.
- Zero wait states. A read returns the register value as it stood at the setup-phase edge.
- Reading COUNT during the setup phase sees the pre-edge value.
- First tick after EN goes 0->1 occurs PRESCALE+1 cycles after the enabling edge.
- EXP and irq assert on the tick edge where COUNT==0. irq is valid in the same cycle as EXP, with no extra latency.
- Back-to-back transfers from the bridge (setup, access, setup, ...) are handled with no dead cycle.

## Configuration
- APB_TIMER_PRESCALER_EN defined: the prescaler is implemented as described.
- APB_TIMER_PRESCALER_EN undefined:
  - No pre_cnt; a tick is generated on every cycle with EN=1.
  - CTRL[15:8] reads 0 and writes to it are ignored.
  - PRE_W is unused.

## Test plan
- Reset, then read all 8 offsets -> every value 0; irq=0 throughout.
- Periodic mode: LOAD=3, CTRL=0x0001 (PRESCALE=0) -> COUNT sequence 3,2,1,0,3,...; EXP set at the 4th tick, then every 4 cycles; irq stays 0.
- One-shot with prescale: LOAD=2, CTRL=0x0307 (PRESCALE=3, ONESHOT=1, IRQ_EN=1) -> expiry 12 cycles after enable; EN reads 0, COUNT stays 0, irq=1; writing STATUS=1 drops irq the next cycle.
- Collision: W1C of STATUS on the same edge as an expiry -> EXP remains 1. LOAD=9 written on a tick edge -> COUNT reads 9, not 8.
- Bus sequence: back-to-back write LOAD=0xA5, then read LOAD, then read offset 5 -> PRDATA=0x000000A5 during the first read's access phase, then 0.
- Assert n_rst mid-count (COUNT=7, EXP=1) -> all registers, PRDATA and irq are 0 immediately; counting does not resume after reset release.
